// File: rtl/mem_stage_if.sv
// mem_stage_if: EX/MEM-side inputs and MEM/WB-side outputs of the memory stage.
interface mem_stage_if;
   logic        WB_en_in, MEM_R_en_in, MEM_W_en_in;
   logic [31:0] ALU_result_in, Val_Rm_in;
   logic [3:0]  Dest_in;
   logic        WB_en, MEM_R_en, ready;
   logic [31:0] ALU_result, Mem_read_value;
   logic [3:0]  Dest;
   modport master (
      output WB_en_in, MEM_R_en_in, MEM_W_en_in, ALU_result_in, Val_Rm_in, Dest_in,
      input  WB_en, MEM_R_en, ALU_result, Dest, Mem_read_value, ready
   );
   modport slave (
      input  WB_en_in, MEM_R_en_in, MEM_W_en_in, ALU_result_in, Val_Rm_in, Dest_in,
      output WB_en, MEM_R_en, ALU_result, Dest, Mem_read_value, ready
   );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage with a fixed-latency word memory and a stall handshake.
module mem_stage #(
   parameter int ADDR_BASE = 1024,
   parameter int DEPTH = 64,
   parameter int ACCESS_CYCLES = 4
) (
   input logic clk,
   input logic rst,
   mem_stage_if.slave bus
);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int CW = ACCESS_CYCLES > 1 ? $clog2(ACCESS_CYCLES) : 1;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t state, nxt;
   logic [CW-1:0] cnt;
   logic [31:0] mem [DEPTH];
   logic [31:0] word, rdata, wdata;
   logic [AW-1:0] idx;
   logic op_w, in_rng, req, last;
   assign bus.WB_en = bus.WB_en_in;
   assign bus.MEM_R_en = bus.MEM_R_en_in;
   assign bus.ALU_result = bus.ALU_result_in;
   assign bus.Dest = bus.Dest_in;
   assign bus.Mem_read_value = rdata;
   assign req = bus.MEM_R_en_in | bus.MEM_W_en_in;
   // unsigned subtraction makes addresses below the base wrap to huge indices
   assign word = (bus.ALU_result_in - 32'(ADDR_BASE)) >> 2;
   assign last = state == BUSY && cnt == '0;
   always_comb begin
      nxt = state == IDLE ? (req ? BUSY : IDLE) : state == BUSY ? (cnt == '0 ? DONE : BUSY) : IDLE;
      bus.ready = state == IDLE ? !req : state == DONE;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         rdata <= '0;
         op_w <= 1'b0;
         in_rng <= 1'b0;
         idx <= '0;
         wdata <= '0;
      end else begin
         state <= nxt;
         if (state == IDLE && req) begin
            op_w <= bus.MEM_W_en_in;
            in_rng <= word < 32'(DEPTH);
            idx <= word[AW-1:0];
            wdata <= bus.Val_Rm_in;
            cnt <= CW'(ACCESS_CYCLES - 1);
         end else if (state == BUSY && cnt != '0) cnt <= cnt - CW'(1);
         if (last && !op_w) rdata <= in_rng ? mem[idx] : '0;
      end
   end
   always_ff @(posedge clk)
      if (!rst && last && op_w && in_rng) mem[idx] <= wdata;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized transaction-level check of mem_stage against a word-array model.
module tb_mem_stage;
   localparam int A = 4, D = 64, B = 1024;
   logic clk = 0, rst = 1, chk_en = 0, exp_ready = 1;
   logic [31:0] exp_mrv = 0;
   logic [31:0] model_mem [D];
   int checks = 0, passed = 0;
   always #5 clk = ~clk;
   mem_stage_if bus();
   mem_stage #(.ADDR_BASE(B), .DEPTH(D), .ACCESS_CYCLES(A)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   always @(negedge clk) if (chk_en) begin
      chk("ready", 32'(bus.ready), 32'(exp_ready));
      chk("mem_read_value", bus.Mem_read_value, exp_mrv);
      chk("alu_pass", bus.ALU_result, bus.ALU_result_in);
      chk("ctl_pass", 32'({bus.WB_en, bus.MEM_R_en, bus.Dest}), 32'({bus.WB_en_in, bus.MEM_R_en_in, bus.Dest_in}));
   end

   task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
      bus.MEM_R_en_in = r;
      bus.MEM_W_en_in = w;
      bus.ALU_result_in = a;
      bus.Val_Rm_in = d;
      bus.WB_en_in = 1'($urandom);
      bus.Dest_in = 4'($urandom);
   endtask

   // one instruction: hold it until the stage lets the pipeline advance
   task automatic issue(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
      logic [31:0] i;
      bit in;
      i = (a - 32'(B)) >> 2;
      in = i < 32'(D);
      drive(r, w, a, d);
      exp_ready = !(r || w);
      if (r || w) begin
         for (int k = 0; k < A; k++) begin
            @(posedge clk); #1;
            bus.ALU_result_in = $urandom;
            bus.Val_Rm_in = $urandom;
         end
         @(posedge clk); #1;
         bus.ALU_result_in = a;
         exp_ready = 1;
         if (w && in) model_mem[int'(i)] = d;
         if (r) exp_mrv = in ? model_mem[int'(i)] : 32'h0;
      end
      @(posedge clk); #1;
      drive(0, 0, $urandom, $urandom);
      exp_ready = 1;
   endtask

   function automatic logic [31:0] rand_addr(input bit oor);
      if (oor) return $urandom_range(0, 1) ? 32'(B) - 32'($urandom_range(1, 16)) : 32'(B + 4 * D) + 32'($urandom_range(0, 255));
      return 32'(B) + 32'(4 * $urandom_range(0, D - 1)) + 32'($urandom_range(0, 3));
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int kind;
      drive(0, 0, 32'h12345678, 0);
      chk_en = 1;
      #2;
      chk("rst_alu_pass", bus.ALU_result, 32'h12345678);
      chk("rst_ready", 32'(bus.ready), 32'h1);
      chk("rst_mrv", bus.Mem_read_value, 32'h0);
      @(posedge clk); #1;
      rst = 0;
      for (int n = 0; n < D; n++) issue(0, 1, 32'(B + 4 * n), $urandom);
      issue(0, 1, 1028, 32'hDEADBEEF);
      chk("store_keeps_mrv", bus.Mem_read_value, 32'h0);
      issue(1, 0, 1028, 0);
      chk("load_1028", bus.Mem_read_value, 32'hDEADBEEF);
      issue(1, 0, 1030, 0);
      chk("load_misaligned", bus.Mem_read_value, 32'hDEADBEEF);
      issue(0, 1, 32'(B + 4 * D), 32'hAAAAAAAA);
      issue(1, 0, 1020, 0);
      chk("load_below_base", bus.Mem_read_value, 32'h0);
      issue(1, 0, 1028, 0);
      chk("oor_store_discarded", bus.Mem_read_value, 32'hDEADBEEF);
      issue(0, 1, 1032, 32'h11111111);
      issue(1, 0, 1028, 0);
      issue(1, 0, 1028, 0);
      // abort a store in its third busy cycle
      drive(0, 1, 1032, 32'h55555555);
      exp_ready = 0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst = 1;
      drive(0, 0, 0, 0);
      exp_ready = 1;
      exp_mrv = 0;
      #1;
      chk("abort_mrv", bus.Mem_read_value, 32'h0);
      chk("abort_ready", 32'(bus.ready), 32'h1);
      @(posedge clk); #1;
      rst = 0;
      issue(1, 0, 1032, 0);
      chk("abort_no_write", bus.Mem_read_value, 32'h11111111);
      repeat (150) begin
         kind = $urandom_range(0, 9);
         if (kind < 2) issue(0, 0, $urandom, $urandom);
         else if (kind < 6) issue(1, 0, rand_addr(0), $urandom);
         else if (kind < 9) issue(0, 1, rand_addr(0), $urandom);
         else issue($urandom_range(0, 1) == 1, 0, rand_addr(1), $urandom);
      end
      for (int n = 0; n < D; n++) issue(1, 0, 32'(B + 4 * n), 0);
      chk_en = 0;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
